// File: rtl/stage_mem_controller.sv
// MEM-stage sequencer: bus handshake, pipeline stall, load extension, write-back.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module stage_mem_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic        register_write_enable_,
  input  logic [4:0]  register_write_address_,
  input  logic [31:0] register_write_data_,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_select,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack,
  output logic        stall_request,
  output logic        bus_error,
  output logic        register_write_enable,
  output logic [4:0]  register_write_address,
  output logic [31:0] register_write_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        align_error
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_d;
  logic [31:0] count, count_d;
  logic        l_write, l_write_d;
  logic [1:0]  l_size, l_size_d;
  logic        l_unsigned, l_unsigned_d;
  logic [1:0]  l_off, l_off_d;
  logic        l_wen, l_wen_d;
  logic [4:0]  l_waddr, l_waddr_d;

  logic        req_d, wr_d, err_d, wen_d;
  logic [31:0] addr_d, wdata_d, rdata_d;
  logic [3:0]  sel_d;
  logic [4:0]  waddr_d;

  logic        mem_op, misalign, issue, timeout_hit;
  logic [1:0]  off;
  logic [3:0]  sel_in;
  logic [31:0] store_in, load_data;
  logic [15:0] lane;

  assign mem_op = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_d;
  assign misalign = (mem_size == 2'd1 && mem_address[0]) ||
                    (mem_size[1] && mem_address[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign issue = (state == IDLE) && mem_op && !misalign;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !bus_ack &&
                       (count == TIMEOUT_CYCLES);
  assign stall_request = issue ||
                         (state == WAIT && !bus_ack && !timeout_hit);

  // Effective offset ignores address bits finer than the access size.
  always_comb begin
    off = 2'b00;
    sel_in = 4'b1111;
    store_in = mem_store_data;
    unique case (1'b1)
      mem_size == 2'd0: begin
        off = mem_address[1:0];
        sel_in = 4'b0001 << off;
        store_in = {4{mem_store_data[7:0]}};
      end
      mem_size == 2'd1: begin
        off = {mem_address[1], 1'b0};
        sel_in = 4'b0011 << off;
        store_in = {2{mem_store_data[15:0]}};
      end
      default: begin
        off = 2'b00;
        sel_in = 4'b1111;
        store_in = mem_store_data;
      end
    endcase
  end

  assign lane = 16'(bus_read_data >> {l_off, 3'b000});

  always_comb begin
    load_data = bus_read_data;
    unique case (1'b1)
      l_size == 2'd0:
        load_data = {{24{lane[7] & ~l_unsigned}}, lane[7:0]};
      l_size == 2'd1:
        load_data = {{16{lane[15] & ~l_unsigned}}, lane[15:0]};
      default:
        load_data = bus_read_data;
    endcase
  end

  always_comb begin
    state_d = state;
    count_d = count;
    l_write_d = l_write;
    l_size_d = l_size;
    l_unsigned_d = l_unsigned;
    l_off_d = l_off;
    l_wen_d = l_wen;
    l_waddr_d = l_waddr;
    req_d = bus_request;
    wr_d = bus_write;
    addr_d = bus_address;
    sel_d = bus_byte_select;
    wdata_d = bus_write_data;
    err_d = 1'b0;
    wen_d = register_write_enable;
    waddr_d = register_write_address;
    rdata_d = register_write_data;
`ifdef MEM_ALIGN_CHECK_EN
    align_d = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_d = WAIT;
          count_d = '0;
          l_write_d = mem_write;
          l_size_d = mem_size;
          l_unsigned_d = mem_unsigned;
          l_off_d = off;
          l_wen_d = register_write_enable_;
          l_waddr_d = register_write_address_;
          req_d = 1'b1;
          wr_d = mem_write;
          addr_d = {mem_address[31:2], 2'b00};
          sel_d = sel_in;
          wdata_d = store_in;
          wen_d = 1'b0;
        end else if (mem_op) begin
          wen_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          align_d = 1'b1;
`endif
        end else begin
          wen_d = register_write_enable_;
          waddr_d = register_write_address_;
          rdata_d = register_write_data_;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          state_d = IDLE;
          req_d = 1'b0;
          wr_d = 1'b0;
          wen_d = !l_write && l_wen;
          if (!l_write) begin
            waddr_d = l_waddr;
            rdata_d = load_data;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          req_d = 1'b0;
          wr_d = 1'b0;
          err_d = 1'b1;
          wen_d = 1'b0;
        end else begin
          count_d = count + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      l_write <= 1'b0;
      l_size <= '0;
      l_unsigned <= 1'b0;
      l_off <= '0;
      l_wen <= 1'b0;
      l_waddr <= '0;
      bus_request <= 1'b0;
      bus_write <= 1'b0;
      bus_address <= '0;
      bus_byte_select <= '0;
      bus_write_data <= '0;
      bus_error <= 1'b0;
      register_write_enable <= 1'b0;
      register_write_address <= '0;
      register_write_data <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      align_error <= 1'b0;
`endif
    end else begin
      state <= state_d;
      count <= count_d;
      l_write <= l_write_d;
      l_size <= l_size_d;
      l_unsigned <= l_unsigned_d;
      l_off <= l_off_d;
      l_wen <= l_wen_d;
      l_waddr <= l_waddr_d;
      bus_request <= req_d;
      bus_write <= wr_d;
      bus_address <= addr_d;
      bus_byte_select <= sel_d;
      bus_write_data <= wdata_d;
      bus_error <= err_d;
      register_write_enable <= wen_d;
      register_write_address <= waddr_d;
      register_write_data <= rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
      align_error <= align_d;
`endif
    end
  end

endmodule

// File: tb/tb_stage_mem_controller.sv
// Bench for stage_mem_controller: vector table, random accesses vs model,
// plus timeout, reset-abort and idle-ack sequences.
module tb_stage_mem_controller;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_address, mem_store_data;
  logic        register_write_enable_;
  logic [4:0]  register_write_address_;
  logic [31:0] register_write_data_;
  logic        bus_request, bus_write;
  logic [31:0] bus_address, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_select;
  logic        bus_ack, stall_request, bus_error;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_error;
`endif

  int checks = 0;
  int errors = 0;

  stage_mem_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .mem_address(mem_address),
    .mem_store_data(mem_store_data),
    .register_write_enable_(register_write_enable_),
    .register_write_address_(register_write_address_),
    .register_write_data_(register_write_data_),
    .bus_request(bus_request),
    .bus_write(bus_write),
    .bus_address(bus_address),
    .bus_byte_select(bus_byte_select),
    .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data),
    .bus_ack(bus_ack),
    .stall_request(stall_request),
    .bus_error(bus_error),
    .register_write_enable(register_write_enable),
    .register_write_address(register_write_address),
    .register_write_data(register_write_data)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_error(align_error)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          lat;
    logic        wen;
    logic [4:0]  waddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] result;
  } acc_t;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic int eff_off(input logic [1:0] size,
                                 input logic [31:0] addr);
    int n = nbytes(size);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] size,
                                       input logic [31:0] addr);
    int n = nbytes(size);
    longint v = ((64'd1 << n) - 1) << eff_off(size, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size,
                                          input logic [31:0] d);
    if (size == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
    if (size == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size,
                                         input logic uns,
                                         input logic [31:0] addr,
                                         input logic [31:0] rd);
    int n = nbytes(size);
    longint v = longint'(rd) >> (8 * eff_off(size, addr));
    longint mask;
    longint res;
    if (n == 4) return rd;
    mask = (64'd1 << (8 * n)) - 1;
    res = v & mask;
    if (!uns && res[8*n-1]) res = res | ~mask;
    return res[31:0];
  endfunction

  task automatic idle_inputs();
    mem_read = 1'b0;
    mem_write = 1'b0;
    register_write_enable_ = 1'b0;
    bus_ack = 1'b0;
  endtask

  task automatic run_access(input acc_t a);
    @(negedge clock);
    mem_read = !a.wr;
    mem_write = a.wr;
    mem_size = a.size;
    mem_unsigned = a.uns;
    mem_address = a.addr;
    mem_store_data = a.sdata;
    register_write_enable_ = a.wen;
    register_write_address_ = a.waddr;
    register_write_data_ = $urandom;
    bus_ack = 1'b0;
    #1 chk("issue_stall", 32'(stall_request), 32'd1);
    @(posedge clock);
    #1;
    chk("req", 32'(bus_request), 32'd1);
    chk("bus_write", 32'(bus_write), 32'(a.wr));
    chk("bus_addr", bus_address, {a.addr[31:2], 2'b00});
    chk("sel", 32'(bus_byte_select), 32'(a.sel));
    if (a.wr) chk("wdata", bus_write_data, a.wdata);
    chk("bubble_wen", 32'(register_write_enable), 32'd0);
    for (int k = 0; k < a.lat && k < TO; k++) begin
      @(negedge clock);
      bus_ack = 1'b0;
      #1;
      chk("wait_stall", 32'(stall_request), 32'd1);
      chk("wait_req", 32'(bus_request), 32'd1);
      chk("wait_addr", bus_address, {a.addr[31:2], 2'b00});
      chk("wait_sel", 32'(bus_byte_select), 32'(a.sel));
    end
    @(negedge clock);
    if (a.lat >= TO) begin
      bus_ack = 1'b0;
      #1 chk("to_stall", 32'(stall_request), 32'd0);
      @(posedge clock);
      #1;
      chk("to_err", 32'(bus_error), 32'd1);
      chk("to_req", 32'(bus_request), 32'd0);
      chk("to_wen", 32'(register_write_enable), 32'd0);
      idle_inputs();
      @(negedge clock);
      #1 chk("to_stall_after", 32'(stall_request), 32'd0);
      @(posedge clock);
      #1;
      chk("to_err_pulse", 32'(bus_error), 32'd0);
      chk("to_req_after", 32'(bus_request), 32'd0);
    end else begin
      bus_ack = 1'b1;
      bus_read_data = a.rdata;
      #1 chk("ack_stall", 32'(stall_request), 32'd0);
      @(posedge clock);
      #1;
      chk("ack_req", 32'(bus_request), 32'd0);
      chk("ack_err", 32'(bus_error), 32'd0);
      chk("ack_wen", 32'(register_write_enable), 32'(!a.wr && a.wen));
      if (!a.wr && a.wen) begin
        chk("ack_waddr", 32'(register_write_address), 32'(a.waddr));
        chk("ack_load", register_write_data, a.result);
      end
      idle_inputs();
    end
  endtask

  acc_t vec[$];
  acc_t r;

  initial begin
    vec.push_back('{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FFFFFF, 2,
                    1'b1, 5'd7, 4'b1000, 32'h0, 32'hFFFFFF80});
    vec.push_back('{1'b1, 2'd1, 1'b0, 32'h2002, 32'hABCD, 32'h0, 1,
                    1'b1, 5'd8, 4'b1100, 32'hABCDABCD, 32'h0});
    vec.push_back('{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h1234ABCD, 0,
                    1'b1, 5'd9, 4'b1100, 32'h0, 32'h00001234});
    vec.push_back('{1'b0, 2'd1, 1'b0, 32'h4000, 32'h0, 32'h0000F00D, 3,
                    1'b1, 5'd10, 4'b0011, 32'h0, 32'hFFFFF00D});
    vec.push_back('{1'b0, 2'd2, 1'b0, 32'h5004, 32'h0, 32'hDEADBEEF, 0,
                    1'b1, 5'd11, 4'b1111, 32'h0, 32'hDEADBEEF});
    vec.push_back('{1'b1, 2'd0, 1'b0, 32'h6001, 32'h123456A5, 32'h0, 1,
                    1'b1, 5'd12, 4'b0010, 32'hA5A5A5A5, 32'h0});
    vec.push_back('{1'b1, 2'd2, 1'b0, 32'h7008, 32'hCAFEF00D, 32'h0, 2,
                    1'b0, 5'd13, 4'b1111, 32'hCAFEF00D, 32'h0});
    vec.push_back('{1'b0, 2'd0, 1'b1, 32'h8001, 32'h0, 32'h00009900, 0,
                    1'b1, 5'd14, 4'b0010, 32'h0, 32'h00000099});
    vec.push_back('{1'b0, 2'd3, 1'b0, 32'h9000, 32'h0, 32'h0, TO + 2,
                    1'b1, 5'd15, 4'b1111, 32'h0, 32'h0});

    reset = 1'b0;
    idle_inputs();
    mem_size = '0;
    mem_unsigned = 1'b0;
    mem_address = '0;
    mem_store_data = '0;
    register_write_address_ = '0;
    register_write_data_ = '0;
    bus_read_data = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req", 32'(bus_request), 32'd0);
    chk("rst_bw", 32'(bus_write), 32'd0);
    chk("rst_addr", bus_address, 32'd0);
    chk("rst_sel", 32'(bus_byte_select), 32'd0);
    chk("rst_wd", bus_write_data, 32'd0);
    chk("rst_err", 32'(bus_error), 32'd0);
    chk("rst_wen", 32'(register_write_enable), 32'd0);
    chk("rst_wa", 32'(register_write_address), 32'd0);
    chk("rst_wdat", register_write_data, 32'd0);
    chk("rst_stall", 32'(stall_request), 32'd0);

    @(negedge clock);
    reset = 1'b1;
    register_write_enable_ = 1'b1;
    register_write_address_ = 5'd3;
    register_write_data_ = 32'h1234;
    #1 chk("alu_stall", 32'(stall_request), 32'd0);
    @(posedge clock);
    #1;
    chk("alu_wen", 32'(register_write_enable), 32'd1);
    chk("alu_wa", 32'(register_write_address), 32'd3);
    chk("alu_wd", register_write_data, 32'h1234);
    chk("alu_req", 32'(bus_request), 32'd0);

    foreach (vec[i]) run_access(vec[i]);

    for (int n = 0; n < 40; n++) begin
      r.wr = 1'($urandom_range(0, 1));
      r.size = 2'($urandom_range(0, 3));
      r.uns = 1'($urandom_range(0, 1));
      r.addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      r.addr[1:0] = 2'(eff_off(r.size, r.addr));
`endif
      r.sdata = $urandom;
      r.rdata = $urandom;
      r.lat = $urandom_range(0, 5);
      r.wen = 1'($urandom_range(0, 1));
      r.waddr = 5'($urandom);
      r.sel = m_sel(r.size, r.addr);
      r.wdata = m_wdata(r.size, r.sdata);
      r.result = m_load(r.size, r.uns, r.addr, r.rdata);
      run_access(r);
    end

    @(negedge clock);
    mem_read = 1'b1;
    mem_size = 2'd2;
    mem_address = 32'hA000;
    register_write_enable_ = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    @(posedge clock);
    #1;
    chk("mid_rst_req", 32'(bus_request), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bus_ack = 1'b1;
    bus_read_data = 32'h13572468;
    #1 chk("late_ack_stall", 32'(stall_request), 32'd0);
    @(posedge clock);
    #1;
    chk("late_ack_wen", 32'(register_write_enable), 32'd0);
    chk("late_ack_req", 32'(bus_request), 32'd0);
    @(negedge clock);
    register_write_enable_ = 1'b1;
    register_write_address_ = 5'd9;
    register_write_data_ = 32'h55;
    @(posedge clock);
    #1;
    chk("idle_ack_wen", 32'(register_write_enable), 32'd1);
    chk("idle_ack_wa", 32'(register_write_address), 32'd9);
    chk("idle_ack_wd", register_write_data, 32'h55);
    chk("idle_ack_req", 32'(bus_request), 32'd0);
    idle_inputs();

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clock);
    mem_read = 1'b1;
    mem_size = 2'd2;
    mem_address = 32'h3001;
    register_write_enable_ = 1'b1;
    #1 chk("al_stall", 32'(stall_request), 32'd0);
    @(posedge clock);
    #1;
    chk("al_err", 32'(align_error), 32'd1);
    chk("al_req", 32'(bus_request), 32'd0);
    chk("al_wen", 32'(register_write_enable), 32'd0);
    idle_inputs();
    @(posedge clock);
    #1 chk("al_pulse", 32'(align_error), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_mem_controller.md
Name: stage_mem_controller

Overview:
- Sequences the MEM-stage data-memory access for loads and stores over a single-port request/acknowledge data bus.
- Produces the register write-back triple for the next stage.
- Raises a pipeline stall request while an access is outstanding.
- Sits between the EX/MEM pipeline register and the MEM/WB register, in place of a pure pass-through MEM stage.

Parameters:
- TIMEOUT_CYCLES, 255, maximum wait cycles for bus_ack before the access is aborted. 0 disables the timeout.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clock edge)
- mem_read  input  1  current instruction is a load
- mem_write  input  1  current instruction is a store. mem_read and mem_write are never both 1.
- mem_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- mem_unsigned  input  1  zero-extend the load result instead of sign-extending
- mem_address  input  32  byte address
- mem_store_data  input  32  store data, right-aligned
- register_write_enable_  input  1  write-back enable from EX
- register_write_address_  input  5  write-back register from EX
- register_write_data_  input  32  ALU result from EX
- bus_request  output  1  access request
- bus_write  output  1  1 = store
- bus_address  output  32  word address (mem_address with bits [1:0] forced to 0)
- bus_byte_select  output  4  active byte lanes
- bus_write_data  output  32  lane-replicated store data
- bus_read_data  input  32  read data, valid with bus_ack
- bus_ack  input  1  access complete
- stall_request  output  1  freeze upstream stages
- bus_error  output  1  one-cycle pulse on timeout
- register_write_enable  output  1  write-back enable to WB
- register_write_address  output  5  write-back register to WB
- register_write_data  output  32  write-back data to WB

Behaviour:
- All outputs except stall_request are registered.
- Reset (reset = 0 at a clock edge): state IDLE; all outputs 0; wait counter 0.
- States: IDLE, WAIT.
- IDLE, no memory op:
  - register_write_* <= inputs, giving 1-cycle latency.
  - bus_request stays 0.
- IDLE, mem_read or mem_write:
  - Latch op, size, unsigned, byte offset (mem_address[1:0]) and write-back address.
  - Next edge drives bus_request = 1 and bus_write = mem_write.
  - Drive bus_address, bus_byte_select and bus_write_data.
  - register_write_enable <= 0 (bubble). Go to WAIT. Counter <= 0.
- Byte select, for offset o:
  - byte: 4'b0001 << o
  - half: 4'b0011 << {o[1], 1'b0}
  - word: 4'b1111
- Store data replication: byte = {4{b}}, half = {2{h}}, word unchanged.
- WAIT:
  - All bus outputs held stable until bus_ack.
  - Counter increments each cycle bus_ack = 0.
- On bus_ack in WAIT:
  - bus_request <= 0; go to IDLE.
  - Load: register_write_enable <= latched enable; address <= latched address.
  - Load data <= the selected lane of bus_read_data, sign- or zero-extended to 32 bits.
  - Store: register_write_enable <= 0.
- stall_request is combinational: (IDLE and (mem_read or mem_write)) or (WAIT and not bus_ack).
  - It is therefore low in the ack cycle, so the pipeline advances on the same edge.
- Access latency = 1 + number of WAIT cycles. Back-to-back accesses are legal; the next request issues one cycle after the ack.
- bus_ack while in IDLE is ignored.
- Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES in WAIT without ack:
  - bus_request <= 0; bus_error pulses 1 for one cycle.
  - register_write_enable <= 0.
  - Go to IDLE; stall_request drops that cycle.
- Reset mid-access: abort immediately; bus_request = 0 on the next cycle; a late bus_ack is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with mem_address[0] = 1, or a word access with mem_address[1:0] != 0, does not issue a bus request.
  - Output align_error (1 bit, registered, reset 0) pulses for one cycle.
  - register_write_enable <= 0; state stays IDLE; stall_request stays 0 for that instruction.
- Not defined:
  - The align_error port is absent.
  - Low address bits beyond the access size are ignored: a half access uses o[1]; a word access uses offset 0.

Test Plan:
- Reset hold, then release; ALU op with enable = 1, address = 5'd3, data = 32'h1234 -> next cycle outputs 1 / 3 / 32'h1234; stall_request and bus_request stay 0.
- LB at 32'h1003, unsigned = 0; bus acks after 2 wait cycles with read data 32'h80FFFFFF -> bus_address 32'h1000, byte select 4'b1000, stall high for 3 cycles, write data 32'hFFFFFF80.
- SH at 32'h2002 with data 32'hABCD -> bus_write = 1, byte select 4'b1100, bus_write_data 32'hABCDABCD, no register write after ack.
- LW with no ack, TIMEOUT_CYCLES = 4 -> bus_error pulses once after 4 wait cycles, then request 0, stall 0, enable 0.
- Reset asserted during WAIT, then an ack arrives -> bus_request 0 after the reset edge; the ack is ignored and no register write occurs.
- With MEM_ALIGN_CHECK_EN defined, LW at 32'h3001 -> align_error pulses for one cycle, no bus_request, stall_request 0.
